// File: rtl/serial_add_sub.sv
// Multi-cycle adder/subtractor. Consumes DIGIT bits per clock through a
// registered carry chain. The result, carry, overflow and zero flags are
// published on the completion edge and held until the next completion.
// Constraint: WIDTH must be an integer multiple of DIGIT, and 1 <= DIGIT <= WIDTH.

// One digit slice of the ripple: sum, carry out, and the carry into the
// slice's top bit. The top-bit carry-in is recovered from the sum bit,
// since s = a ^ b ^ cin holds at every bit position.
module serial_add_sub_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             cmsb
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
    assign cmsb      = a[DIGIT-1] ^ b[DIGIT-1] ^ s[DIGIT-1];
endmodule

module serial_add_sub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] psum_next;
    logic             c_r;
    logic [CNT_W-1:0] cnt;

    logic [DIGIT-1:0] slice_s;
    logic             slice_cout;
    logic             slice_cmsb;
    logic             accept;
    logic             last;

    // start is honoured whenever no operation is running, including the DONE cycle
    assign accept = start && (state != RUN);
    assign last   = (state == RUN) && (cnt == CNT_W'(N - 1));

    serial_add_sub_slice #(.DIGIT(DIGIT)) u_slice (
        .a    (a_r[DIGIT-1:0]),
        .b    (b_r[DIGIT-1:0]),
        .cin  (c_r),
        .s    (slice_s),
        .cout (slice_cout),
        .cmsb (slice_cmsb)
    );

    // New digits enter at the top of the partial sum, so after N slices the
    // least significant digit has arrived at bit 0.
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign psum_next = slice_s;
        end else begin : g_multi
            assign psum_next = {slice_s, psum[WIDTH-1:DIGIT]};
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, digit-serial datapath, and result publication on the last slice
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            psum     <= '0;
            c_r      <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1: invert b and use mode as the carry-in
            a_r <= a;
            b_r <= b ^ {WIDTH{mode}};
            c_r <= mode;
            cnt <= '0;
        end else if (state == RUN) begin
            a_r  <= a_r >> DIGIT;
            b_r  <= b_r >> DIGIT;
            psum <= psum_next;
            c_r  <= slice_cout;
            cnt  <= cnt + CNT_W'(1);
            if (last) begin
                sum      <= psum_next;
                carry    <= slice_cout;
                overflow <= slice_cmsb ^ slice_cout;
                zero     <= (psum_next == '0);
            end
        end
    end
endmodule

// File: tb/tb_serial_add_sub.sv
// Directed checks of the WIDTH=16/DIGIT=4 adder/subtractor, plus random
// sweeps of DIGIT=1, 8 and 16 instances against a behavioural model.
module tb_serial_add_sub;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        mode = 1'b0;
    logic        busy, done, carry, overflow, zero;
    logic [15:0] sum;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .mode(mode),
        .busy(busy), .done(done), .sum(sum), .carry(carry),
        .overflow(overflow), .zero(zero)
    );

    // Sweep instances: index 0 -> DIGIT=1, 1 -> DIGIT=8, 2 -> DIGIT=16
    logic        s_start [3];
    logic [15:0] s_a     [3];
    logic [15:0] s_b     [3];
    logic        s_mode  [3];
    logic        s_busy  [3];
    logic        s_done  [3];
    logic [15:0] s_sum   [3];
    logic        s_carry [3];
    logic        s_ov    [3];
    logic        s_zero  [3];

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int DG = (g == 0) ? 1 : (g == 1) ? 8 : 16;
        serial_add_sub #(.WIDTH(16), .DIGIT(DG)) u_dut (
            .clk(clk), .rst(rst), .start(s_start[g]), .a(s_a[g]), .b(s_b[g]),
            .mode(s_mode[g]), .busy(s_busy[g]), .done(s_done[g]), .sum(s_sum[g]),
            .carry(s_carry[g]), .overflow(s_ov[g]), .zero(s_zero[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operation and hold start across exactly one edge
    task automatic launch(input logic [15:0] ta, input logic [15:0] tb_, input logic tm);
        a = ta; b = tb_; mode = tm; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Count edges from the start-sampling edge (counted as 1) until done is seen
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 1;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
            if (busy) bcnt++;
        end
    endtask

    task automatic check_result(input string name, input logic [15:0] es,
                                input logic ec, input logic eo, input logic ez);
        n_cmp++;
        if ({sum, carry, overflow, zero} !== {es, ec, eo, ez}) begin
            n_bad++;
            $display("FAIL %s: got sum=%h c=%b v=%b z=%b, want sum=%h c=%b v=%b z=%b",
                     name, sum, carry, overflow, zero, es, ec, eo, ez);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({busy, done, sum, carry, overflow, zero} !== 21'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h c=%b v=%b z=%b, want all 0",
                     busy, done, sum, carry, overflow, zero);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_add();
        int lat, bc;
        launch(16'h0005, 16'h0003, 1'b0);
        wait_done(lat, bc);
        n_cmp++;
        if (lat !== 5) begin
            n_bad++;
            $display("FAIL add_latency: got %0d edges, want 5", lat);
        end
        n_cmp++;
        if (bc !== 4) begin
            n_bad++;
            $display("FAIL add_busy_cycles: got %0d, want 4", bc);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL add_busy_in_done: got %b, want 0", busy);
        end
        check_result("add_5_3", 16'h0008, 1'b0, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL done_one_cycle: got %b, want 0", done);
        end
    endtask

    task automatic test_sub();
        int lat, bc;
        launch(16'h0005, 16'h0003, 1'b1);
        wait_done(lat, bc);
        check_result("sub_5_3", 16'h0002, 1'b1, 1'b0, 1'b0);
        tick();
        launch(16'h0003, 16'h0005, 1'b1);
        wait_done(lat, bc);
        check_result("sub_3_5", 16'hFFFE, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_overflow();
        int lat, bc;
        launch(16'h7FFF, 16'h0001, 1'b0);
        wait_done(lat, bc);
        check_result("add_7fff_1", 16'h8000, 1'b0, 1'b1, 1'b0);
        tick();
        launch(16'hFFFF, 16'h0001, 1'b0);
        wait_done(lat, bc);
        check_result("add_ffff_1", 16'h0000, 1'b1, 1'b0, 1'b1);
        tick();
        launch(16'h8000, 16'h0001, 1'b1);
        wait_done(lat, bc);
        check_result("sub_8000_1", 16'h7FFF, 1'b1, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_ignore_start();
        int lat, bc;
        launch(16'h1234, 16'h1111, 1'b0);
        tick();
        // Retrigger while busy with different operands; these must be ignored
        a = 16'hAAAA; b = 16'h5555; mode = 1'b1; start = 1'b1;
        tick(); tick();
        start = 1'b0;
        lat = 4;
        bc = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        n_cmp++;
        if (lat !== 5) begin
            n_bad++;
            $display("FAIL ignore_latency: got %0d edges, want 5", lat);
        end
        check_result("ignore_start", 16'h2345, 1'b0, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++;
            $display("FAIL ignore_no_requeue: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        launch(16'h0010, 16'h0020, 1'b0);
        wait_done(lat, bc);
        check_result("b2b_first", 16'h0030, 1'b0, 1'b0, 1'b0);
        // Start presented in the DONE cycle
        launch(16'h0100, 16'h0001, 1'b1);
        n_cmp++;
        if ({busy, done} !== 2'b10) begin
            n_bad++;
            $display("FAIL b2b_accept: got busy=%b done=%b, want 1 0", busy, done);
        end
        check_result("b2b_hold", 16'h0030, 1'b0, 1'b0, 1'b0);
        wait_done(lat, bc);
        n_cmp++;
        if (lat !== 5) begin
            n_bad++;
            $display("FAIL b2b_latency: got %0d edges, want 5", lat);
        end
        check_result("b2b_second", 16'h00FF, 1'b1, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        int seen;
        launch(16'h0F0F, 16'h0101, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({busy, done, sum, carry, overflow, zero} !== 21'd0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: got busy=%b done=%b sum=%h c=%b v=%b z=%b, want all 0",
                     busy, done, sum, carry, overflow, zero);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done || busy) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL reset_mid_quiet: got %0d active cycles, want 0", seen);
        end
        launch(16'h0F0F, 16'h0101, 1'b0);
        wait_done(lat, bc);
        n_cmp++;
        if (lat !== 5) begin
            n_bad++;
            $display("FAIL reset_mid_relaunch_latency: got %0d, want 5", lat);
        end
        check_result("reset_mid_relaunch", 16'h1010, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_sweep(input int g, input int digit, input int iters);
        logic [15:0] ra, rb, bb, es;
        logic        rm, ec, eo, ez;
        logic [16:0] full;
        int          lat;
        int          exp_lat;
        exp_lat = 16 / digit + 1;
        for (int it = 0; it < iters; it++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rm = 1'($urandom);
            if (it < 4) begin
                // Corner operands first
                ra = (it < 2) ? 16'h7FFF : 16'h0000;
                rb = (it[0]) ? 16'hFFFF : 16'h0001;
            end
            bb   = rm ? ~rb : rb;
            full = {1'b0, ra} + {1'b0, bb} + {16'd0, rm};
            es   = full[15:0];
            ec   = full[16];
            eo   = (ra[15] == bb[15]) && (es[15] != ra[15]);
            ez   = (es == 16'd0);
            s_a[g] = ra; s_b[g] = rb; s_mode[g] = rm; s_start[g] = 1'b1;
            tick();
            s_start[g] = 1'b0;
            lat = 1;
            while (!s_done[g] && lat < 60) begin
                tick();
                lat++;
            end
            n_cmp++;
            if (lat !== exp_lat) begin
                n_bad++;
                $display("FAIL sweep_d%0d_latency it=%0d: got %0d, want %0d", digit, it, lat, exp_lat);
            end
            n_cmp++;
            if ({s_sum[g], s_carry[g], s_ov[g], s_zero[g]} !== {es, ec, eo, ez}) begin
                n_bad++;
                $display("FAIL sweep_d%0d it=%0d a=%h b=%h m=%b: got %h %b %b %b, want %h %b %b %b",
                         digit, it, ra, rb, rm, s_sum[g], s_carry[g], s_ov[g], s_zero[g],
                         es, ec, eo, ez);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            s_start[i] = 1'b0; s_a[i] = '0; s_b[i] = '0; s_mode[i] = 1'b0;
        end
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_sweep(0, 1, 1000);
        test_sweep(1, 8, 1000);
        test_sweep(2, 16, 1000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Parametrised, multi-cycle adder/subtractor. Computes a+b or a-b over WIDTH bits, processing DIGIT bits per clock with a registered carry chain.
- Trades latency for area. Replaces the fixed 4-bit ripple add/sub in datapaths where WIDTH is large and timing or area is tight.
- Adds start/busy/done handshake, signed-overflow flag and zero flag.

Parameters:
- WIDTH, 16, operand/result width in bits; must be an integer multiple of DIGIT.
- DIGIT, 4, bits processed per RUN cycle; 1 <= DIGIT <= WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- mode  input  1  0 = add (a+b), 1 = subtract (a-b); captured on accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; results valid and updated
- sum  output  WIDTH  result, registered
- carry  output  1  carry out of MSB; for subtract, 1 = no borrow (a >= b unsigned)
- overflow  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB)
- zero  output  1  sum == 0

Behaviour:
- One clock, clk. rst is synchronous and active-high.
- Reset: state=IDLE; busy, done, sum, carry, overflow, zero all 0; internal operand, carry and count registers cleared.
- Reset mid-operation aborts the operation. No done pulse; outputs go to 0.
- N = WIDTH/DIGIT.
- States: IDLE, RUN, DONE.
- IDLE, start=1 (accepted):
  - Capture a_r=a, b_r=b XOR {WIDTH{mode}}, c_r=mode, cnt=0.
  - Go to RUN; busy=1 from the next cycle.
- RUN, each edge:
  - Add digit slice a_r[DIGIT-1:0] + b_r[DIGIT-1:0] + c_r.
  - Shift a_r and b_r right by DIGIT.
  - Shift the result slice into the top of the partial-sum register.
  - Update c_r with the slice carry out; increment cnt.
- On the edge where cnt == N-1:
  - Load sum from the completed partial-sum register.
  - carry = final slice carry out.
  - overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, derived inside the last slice.
  - zero = (completed sum == 0).
  - Go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Latency: start sampled at edge k; slices processed at edges k+1..k+N; done high in the cycle after edge k+N.
  - WIDTH=16, DIGIT=4: done after 5 edges.
  - DIGIT=WIDTH: N=1, done after 2 edges.
- Accepting start:
  - start is accepted in IDLE or DONE (busy=0).
  - Start during the DONE cycle is accepted: back-to-back operation, no idle bubble.
  - Start while busy=1 is ignored. No queuing, and the current operation is unaffected.
- Result holding:
  - sum, carry, overflow and zero change only on the completion edge.
  - They hold their values through IDLE and through the whole of the next operation until its completion.
- Arithmetic:
  - Modulo 2^WIDTH.
  - Subtract is a + ~b + 1 (mode as carry-in).
  - Operand changes after capture have no effect.

Test Plan:
- WIDTH=16, DIGIT=4; a=0x0005, b=0x0003, mode=0, start pulse -> done exactly 5 edges later; sum=0x0008, carry=0, overflow=0, zero=0; busy high 4 cycles.
- Same operands, mode=1 -> sum=0x0002, carry=1; then a=0x0003, b=0x0005, mode=1 -> sum=0xFFFE, carry=0, overflow=0.
- a=0x7FFF, b=0x0001, add -> sum=0x8000, overflow=1, carry=0; a=0xFFFF, b=0x0001, add -> sum=0x0000, carry=1, zero=1, overflow=0.
- Start during RUN with different operands -> ignored; first result unchanged. Start asserted in DONE cycle -> second op accepted, its done 5 edges later, no gap.
- rst asserted on 2nd RUN cycle -> no done pulse; all outputs 0 next cycle; a following start completes normally.
- Parameter sweep DIGIT=1, 8, 16 with random operands and modes (≥1000 each) vs. reference model -> sum/carry/overflow/zero match; latency N+1 edges each.
